// File: rtl/hamming_decoder_datapath_pkg.sv
// Shared constants for the (15,11) Hamming receive datapath.
package hamming_decoder_datapath_pkg;

  localparam int unsigned CW_WIDTH   = 15;
  localparam int unsigned DATA_WIDTH = 11;
  localparam int unsigned SYN_WIDTH  = 4;

  // Hamming positions (1-based) of the parity bits; entry b covers syndrome bit b.
  localparam logic [SYN_WIDTH-1:0] PARITY_POS [SYN_WIDTH] = '{4'd1, 4'd2, 4'd4, 4'd8};

  // Hamming positions (1-based) of d0..d10, shared with the transmit encoder.
  localparam logic [SYN_WIDTH-1:0] DATA_POS [DATA_WIDTH] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  typedef enum logic {
    OUT_IDLE,
    OUT_ACTIVE
  } out_state_t;

endpackage

// File: rtl/hamming_decoder_datapath_syndrome.sv
// Combinational syndrome computation and single-bit correction of one codeword.
module hamming_syndrome_corrector
  import hamming_decoder_datapath_pkg::*;
(
  input  logic [CW_WIDTH-1:0]   word,
  output logic [SYN_WIDTH-1:0]  syndrome,
  output logic [DATA_WIDTH-1:0] data
);

  logic [CW_WIDTH-1:0] fixed;

  // Syndrome bit b is the parity of every position whose index has bit b set.
  always_comb begin
    syndrome = '0;
    for (int unsigned b = 0; b < SYN_WIDTH; b++) begin
      for (int unsigned i = 0; i < CW_WIDTH; i++) begin
        if ((SYN_WIDTH'(i + 1) & PARITY_POS[b]) != '0) begin
          syndrome[b] = syndrome[b] ^ word[i];
        end
      end
    end
  end

  // Flip the bit named by a nonzero syndrome, then gather the data positions.
  always_comb begin
    fixed = word;
    if (syndrome != '0) begin
      fixed[syndrome - SYN_WIDTH'(1)] = ~word[syndrome - SYN_WIDTH'(1)];
    end
    data = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      data[i] = fixed[DATA_POS[i] - SYN_WIDTH'(1)];
    end
  end

endmodule

// File: rtl/hamming_decoder_datapath.sv
// (15,11) Hamming receive stage: deserialize, correct, re-serialize data bits.
module hamming_decoder_datapath
  import hamming_decoder_datapath_pkg::*;
(
  input  logic                 CLK,
  input  logic                 REST,
  input  logic                 DEVICE_EN,
  input  logic                 SERIAL_IN,
  output logic                 SERIAL_OUT,
  output logic                 OUT_VALID,
  output logic                 FRAME_DONE,
  output logic                 ERR_FLAG,
  output logic [SYN_WIDTH-1:0] ERR_POS
);

  logic [CW_WIDTH-2:0]   rx_sr;
  logic [SYN_WIDTH-1:0]  rx_cnt;
  logic [DATA_WIDTH-1:0] out_sr;
  logic [SYN_WIDTH-1:0]  out_cnt;
  logic [CW_WIDTH-1:0]   rx_word;
  logic [SYN_WIDTH-1:0]  dec_syn;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  load;
  logic                  last_out_bit;
  out_state_t            state, state_next;

  // The current line bit completes the word on the decode edge.
  assign rx_word      = {rx_sr, SERIAL_IN};
  assign load         = DEVICE_EN && (rx_cnt == SYN_WIDTH'(CW_WIDTH - 1));
  assign last_out_bit = (out_cnt == SYN_WIDTH'(DATA_WIDTH - 1));

  hamming_syndrome_corrector u_corrector (
    .word     (rx_word),
    .syndrome (dec_syn),
    .data     (dec_data)
  );

  // Receive shifter and bit counter; DEVICE_EN low pauses without aborting.
  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      rx_sr  <= '0;
      rx_cnt <= '0;
    end else if (DEVICE_EN) begin
      rx_sr  <= {rx_sr[CW_WIDTH-3:0], SERIAL_IN};
      rx_cnt <= load ? '0 : rx_cnt + SYN_WIDTH'(1);
    end
  end

  // Decode results and the frame-done strobe.
  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      ERR_FLAG   <= 1'b0;
      ERR_POS    <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= load;
      if (load) begin
        ERR_FLAG <= (dec_syn != '0);
        ERR_POS  <= dec_syn;
      end
    end
  end

  // Output state register.
  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      state <= OUT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output window control: a fresh load always (re)starts the window.
  always_comb begin
    state_next = state;
    case (state)
      OUT_IDLE:   if (load) state_next = OUT_ACTIVE;
      OUT_ACTIVE: if (!load && last_out_bit) state_next = OUT_IDLE;
      default:    state_next = OUT_IDLE;
    endcase
  end

  // Output shifter, d10 first; free-running regardless of DEVICE_EN.
  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      out_sr  <= '0;
      out_cnt <= '0;
    end else if (load) begin
      out_sr  <= dec_data;
      out_cnt <= '0;
    end else if (state == OUT_ACTIVE) begin
      out_sr  <= {out_sr[DATA_WIDTH-2:0], 1'b0};
      out_cnt <= out_cnt + SYN_WIDTH'(1);
    end
  end

  // Serial output is forced low outside the valid window.
  always_comb begin
    OUT_VALID  = (state == OUT_ACTIVE);
    SERIAL_OUT = OUT_VALID & out_sr[DATA_WIDTH-1];
  end

endmodule

// File: tb/tb_hamming_decoder_datapath.sv
// Scoreboard bench for hamming_decoder_datapath with a positional Hamming model.
module tb_hamming_decoder_datapath;

  logic       CLK = 1'b0;
  logic       REST;
  logic       DEVICE_EN;
  logic       SERIAL_IN;
  logic       SERIAL_OUT;
  logic       OUT_VALID;
  logic       FRAME_DONE;
  logic       ERR_FLAG;
  logic [3:0] ERR_POS;

  hamming_decoder_datapath dut (
    .CLK        (CLK),
    .REST       (REST),
    .DEVICE_EN  (DEVICE_EN),
    .SERIAL_IN  (SERIAL_IN),
    .SERIAL_OUT (SERIAL_OUT),
    .OUT_VALID  (OUT_VALID),
    .FRAME_DONE (FRAME_DONE),
    .ERR_FLAG   (ERR_FLAG),
    .ERR_POS    (ERR_POS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [10:0] data;
    int          pos;
    int          cyc;
  } exp_t;

  localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Data bits land on their positions; parity bits are chosen so that the
  // XOR of all set positions is zero.
  function automatic logic [14:0] encode(input logic [10:0] d);
    logic [14:0] cw;
    int          s;
    cw = '0;
    s  = 0;
    for (int k = 0; k < 11; k++) begin
      if (d[k]) begin
        cw[DPOS[k]-1] = 1'b1;
        s = s ^ DPOS[k];
      end
    end
    for (int b = 0; b < 4; b++) cw[(1 << b) - 1] = s[b];
    return cw;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      DEVICE_EN = 1'b0;
      SERIAL_IN = 1'($urandom);
    end
  endtask

  // Sends one codeword (optionally with position flip_pos inverted and a
  // receive pause after line bit pause_after) and queues the expected result.
  task automatic send(input logic [10:0] d, input int flip_pos,
                      input int pause_after, input int pause_len);
    logic [14:0] cw;
    exp_t        e;
    int          c0;
    cw = encode(d);
    if (flip_pos != 0) cw[flip_pos-1] = ~cw[flip_pos-1];
    c0 = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (k == 0) c0 = cyc;
      DEVICE_EN = 1'b1;
      SERIAL_IN = cw[14-k];
      if (k == pause_after) begin
        repeat (pause_len) begin
          @(negedge CLK);
          DEVICE_EN = 1'b0;
          SERIAL_IN = 1'($urandom);
        end
      end
    end
    e.data = d;
    e.pos  = flip_pos;
    e.cyc  = c0 + 15 + ((pause_after >= 0) ? pause_len : 0);
    exp_q.push_back(e);
  endtask

  task automatic send_partial(input logic [10:0] d, input int nbits);
    logic [14:0] cw;
    cw = encode(d);
    for (int k = 0; k < nbits; k++) begin
      @(negedge CLK);
      DEVICE_EN = 1'b1;
      SERIAL_IN = cw[14-k];
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, {SERIAL_OUT, OUT_VALID, FRAME_DONE, ERR_FLAG, ERR_POS}, 0);
  endtask

  task automatic pulse_reset(input string name);
    #2 REST = 1'b0;
    #1 check_zero(name);
    repeat (2) begin
      @(negedge CLK);
      DEVICE_EN = 1'b0;
    end
    @(negedge CLK);
    REST = 1'b1;
  endtask

  // Monitor: pops an expectation on each FRAME_DONE and collects the window.
  exp_t        cur;
  bit          collecting = 0;
  int          nbits      = 0;
  logic [10:0] got        = '0;

  always @(negedge CLK) begin
    if (!REST) begin
      collecting = 0;
      nbits      = 0;
    end else begin
      if (FRAME_DONE) begin
        chk("frame_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("err_pos", ERR_POS, cur.pos);
          chk("err_flag", ERR_FLAG, int'(cur.pos != 0));
          chk("done_cycle", cyc, cur.cyc);
          collecting = 1;
          nbits      = 0;
          got        = '0;
        end
      end
      if (OUT_VALID) begin
        chk("valid_in_window", int'(collecting), 1);
        if (collecting) begin
          got = {got[9:0], SERIAL_OUT};
          nbits++;
          if (nbits == 11) begin
            chk("out_data", got, cur.data);
            collecting = 0;
          end
        end
      end else begin
        chk("idle_serial_out", SERIAL_OUT, 0);
        if (collecting) begin
          chk("window_length", nbits, 11);
          collecting = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    REST      = 1'b0;
    DEVICE_EN = 1'b0;
    SERIAL_IN = 1'b0;
    #1 check_zero("reset_state");
    idle(3);
    REST = 1'b1;

    // Directed frames: clean, data-bit error, parity-bit error.
    send(11'h400, 0, -1, 0);
    idle(3);
    send(11'h400, 5, -1, 0);
    idle(3);
    send(11'h400, 8, -1, 0);
    idle(3);

    // Back-to-back stream.
    send(11'h400, 0, -1, 0);
    send(11'h7FF, 0, -1, 0);
    send(11'h000, 0, -1, 0);
    idle(16);

    // Pause after line bit 7.
    send(11'h2A5, 0, 7, 5);
    idle(16);

    // Reset while receiving bit 9, then a full frame.
    send(11'h7FF, 0, -1, 0);
    idle(16);
    send_partial(11'h155, 10);
    pulse_reset("reset_mid_frame");
    send(11'h155, 3, -1, 0);
    idle(4);

    // Reset inside an output window, then a full frame.
    pulse_reset("reset_mid_window");
    send(11'h3C3, 15, -1, 0);
    idle(16);

    // Random frames with at most one flipped bit, random pauses and gaps.
    for (int n = 0; n < 40; n++) begin
      logic [10:0] d;
      int          fp, pa, pl;
      d  = 11'($urandom);
      fp = int'($urandom_range(0, 15));
      pa = -1;
      pl = 0;
      if ($urandom_range(0, 3) == 0) begin
        pa = int'($urandom_range(0, 13));
        pl = int'($urandom_range(1, 6));
      end
      send(d, fp, pa, pl);
      idle(int'($urandom_range(0, 3)));
    end

    idle(20);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hamming_decoder_datapath.md
Name: hamming_decoder_datapath

Overview:
Receive-side (15,11) Hamming stage that sits directly downstream of the transmit encoder datapath. It deserializes 15-bit codewords from the serial line and computes the 4-bit syndrome. It corrects any single-bit error, then re-serializes the 11 corrected data bits with a valid strobe. Receive and output sides are double-buffered, so back-to-back codewords stream with no gaps.

Parameters:
CW_WIDTH, 15, codeword length; only the default is supported.
DATA_WIDTH, 11, data bits per codeword; only the default is supported.
SYN_WIDTH, 4, syndrome / bit-counter width.

Ports:
CLK  in  1  single clock; all state updates on the rising edge.
REST  in  1  asynchronous active-low reset.
DEVICE_EN  in  1  receive enable; SERIAL_IN is sampled only when high.
SERIAL_IN  in  1  received codeword bit stream.
SERIAL_OUT  out  1  corrected data bit stream.
OUT_VALID  out  1  high while SERIAL_OUT carries a data bit.
FRAME_DONE  out  1  one-cycle pulse when a codeword has been decoded.
ERR_FLAG  out  1  syndrome nonzero for the most recent codeword.
ERR_POS  out  4  syndrome value = corrected bit position (1..15); 0 means no error.

Behaviour:
- Reset (REST=0, asynchronous):
  - Clears rx shift register, rx counter, output shift register and output counter.
  - All outputs go to 0.
  - Reset mid-frame discards the partial codeword and any unsent data bits; reception restarts at bit 0 after release.
- Codeword layout:
  - CW[i] holds Hamming position i+1. Parity bits are at positions 1, 2, 4, 8.
  - d0..d10 occupy positions 3,5,6,7,9,10,11,12,13,14,15 in ascending order.
  - Line order is CW[14] first, CW[0] last.
- Receive side:
  - On each edge with DEVICE_EN=1: rx_sr <= {rx_sr[13:0], SERIAL_IN}; rx_cnt increments 0..14, then wraps to 0.
  - DEVICE_EN=0 freezes rx_sr and rx_cnt (frame paused, not aborted).
- Decode: on the edge where rx_cnt==14 and DEVICE_EN=1, the full word W={rx_sr[13:0],SERIAL_IN} is decoded.
  - Syndrome S = XOR of (i+1) over all i with W[i]=1.
  - If S!=0, W[S-1] is inverted. This is single-error correction only; double errors are miscorrected silently.
  - In the same edge: out_sr <= extracted 11 data bits; ERR_POS <= S; ERR_FLAG <= (S!=0); out_cnt <= 0; out_active <= 1.
  - FRAME_DONE is high for the following cycle only.
- Output side:
  - Free-running, not gated by DEVICE_EN.
  - SERIAL_OUT = out_sr MSB (d10 first, d0 last).
  - OUT_VALID=1 for exactly 11 cycles after the load edge; out_sr shifts left each cycle.
  - After the 11th bit: out_active=0, OUT_VALID=0, SERIAL_OUT=0.
- Latency: the last codeword bit is sampled at edge N. d10 appears on SERIAL_OUT in the cycle after N, and d0 in cycle N+11.
- Back-to-back frames: the next load occurs at least 15 cycles later, after the 11-bit output window closes.
  - If a load coincides with an active output (not reachable in normal operation), the load wins and restarts the output.
- ERR_FLAG and ERR_POS hold their values until the next decode or a reset.

Decomposition:
- Shared package holds:
  - CW_WIDTH, DATA_WIDTH, SYN_WIDTH.
  - Parity position constants 1, 2, 4, 8.
  - The 11-entry data-position table, shared with the encoder.
- One combinational sub-module, hamming_syndrome_corrector: 15-bit word in; 4-bit syndrome and 11 corrected data bits out.
- Counters and FSM (IDLE/ACTIVE output state) stay in the top module.

Test Plan:
- Clean frame: data 11'h400 gives CW=15'h408B, sent on the line as 1,0,0,0,0,0,0,1,0,0,0,1,0,1,1 with DEVICE_EN=1 → FRAME_DONE pulse, ERR_FLAG=0, ERR_POS=0; SERIAL_OUT = 1 then ten 0s, with OUT_VALID high for 11 cycles.
- Data-bit error: the same frame with CW[4] flipped (CW=15'h409B) → ERR_POS=5, ERR_FLAG=1, output data still 11'h400.
- Parity-bit error: CW[7] flipped (CW=15'h400B) → ERR_POS=8, ERR_FLAG=1, data 11'h400 unchanged.
- Streaming: frames 11'h400, 11'h7FF, 11'h000 sent back-to-back → three FRAME_DONE pulses 15 cycles apart; each output window is 11 valid cycles followed by 4 idle cycles, with correct data in each window.
- Pause: DEVICE_EN held low for 5 cycles after bit 7 of a frame → rx holds state, and the decoded result is identical to the unpaused case, delayed by 5 cycles.
- Reset: REST asserted low during bit 9 of a frame and during an output window → all outputs 0 immediately; after release, the next full 15-bit frame decodes correctly.
